// File: rtl/cpu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// cpu_pkg : shared PC width, reset vector, fetch-sequencer states, PC increment
// Revision: 1.0
// ============================================================================
package cpu_pkg;

   localparam int          PC_W     = 12;
   localparam logic [11:0] RESET_PC = 12'd0;

   typedef enum logic [1:0] {
      PCS_BOOT = 2'd0,
      PCS_RUN  = 2'd1,
      PCS_HOLD = 2'd2
   } pcs_state_t;

   // Wraps naturally because the result is truncated to PC_W bits.
   function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
      return pc + {{(PC_W-1){1'b0}}, 1'b1};
   endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/pc_redirect_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// pc_redirect_buf : one-entry pending-redirect register, branch beats jump
// Revision: 1.0
// ============================================================================
module pc_redirect_buf
   import cpu_pkg::*;
#(
   parameter int PC_W = cpu_pkg::PC_W
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            capture,
   input  logic            clear,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   input  logic            jump,
   input  logic [PC_W-1:0] jump_target,
   output logic            redir,
   output logic [PC_W-1:0] sel_target,
   output logic            pend_valid,
   output logic [PC_W-1:0] pend_target
);

   logic            pend_valid_d, pend_valid_q;
   logic [PC_W-1:0] pend_target_d, pend_target_q;

   always_comb begin
      redir         = br_taken | jump;
      sel_target    = br_taken ? br_target : jump_target;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      // A fresh capture always wins over a clear in the same cycle.
      if (capture) begin
         pend_valid_d  = 1'b1;
         pend_target_d = sel_target;
      end else if (clear) begin
         pend_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
      end else begin
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
      end
   end

   assign pend_valid  = pend_valid_q;
   assign pend_target = pend_target_q;

endmodule : pc_redirect_buf
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// pc_fetch_sequencer : next-PC selection, PC register write and imem fetch
// Revision: 1.0
// ============================================================================
module pc_fetch_sequencer
   import cpu_pkg::*;
#(
   parameter int              PC_W     = cpu_pkg::PC_W,
   parameter logic [PC_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            stall,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   input  logic            jump,
   input  logic [PC_W-1:0] jump_target,
   input  logic            fetch_ready,
   output logic            fetch_valid,
   output logic [PC_W-1:0] fetch_pc,
   output logic [PC_W-1:0] pc_next,
   output logic            pc_en,
   output logic            flush
);

   pcs_state_t      state_d, state_q;
   logic            fetch_valid_d, fetch_valid_q;
   logic            flush_d, flush_q;
   logic [PC_W-1:0] fetch_pc_d, fetch_pc_q;

   logic            pc_wr;
   logic            capture;
   logic            pend_clr;
   logic            redir;
   logic [PC_W-1:0] sel_target;
   logic            pend_valid;
   logic [PC_W-1:0] pend_target;

   pc_redirect_buf #(
      .PC_W (PC_W)
   ) u_redirect_buf (
      .clk         (clk),
      .clr         (clr),
      .capture     (capture),
      .clear       (pend_clr),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .jump        (jump),
      .jump_target (jump_target),
      .redir       (redir),
      .sel_target  (sel_target),
      .pend_valid  (pend_valid),
      .pend_target (pend_target)
   );

   always_comb begin
      state_d       = state_q;
      fetch_valid_d = fetch_valid_q;
      flush_d       = 1'b0;
      pc_next       = fetch_pc_q;
      pc_wr         = 1'b0;
      capture       = 1'b0;
      pend_clr      = 1'b0;

      case (state_q)
         PCS_BOOT: begin
            state_d       = PCS_RUN;
            fetch_valid_d = 1'b1;
         end

         PCS_RUN: begin
            if (stall) begin
               state_d = PCS_HOLD;
               capture = redir;
            end else if (redir) begin
               pc_next = sel_target;
               pc_wr   = 1'b1;
               flush_d = 1'b1;
            end else if (fetch_ready) begin
               pc_next = pc_inc(fetch_pc_q);
               pc_wr   = 1'b1;
            end
         end

         PCS_HOLD: begin
            if (stall) begin
               capture = redir;
            end else begin
               // A live redirect on release supersedes whatever was parked.
               state_d  = PCS_RUN;
               pend_clr = 1'b1;
               if (redir) begin
                  pc_next = sel_target;
                  pc_wr   = 1'b1;
                  flush_d = 1'b1;
               end else if (pend_valid) begin
                  pc_next = pend_target;
                  pc_wr   = 1'b1;
                  flush_d = 1'b1;
               end else if (fetch_ready) begin
                  pc_next = pc_inc(fetch_pc_q);
                  pc_wr   = 1'b1;
               end
            end
         end

         default: begin
            state_d       = PCS_BOOT;
            fetch_valid_d = 1'b0;
         end
      endcase

      fetch_pc_d = pc_wr ? pc_next : fetch_pc_q;
      pc_en      = pc_wr & ~clr;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q       <= PCS_BOOT;
         fetch_valid_q <= 1'b0;
         flush_q       <= 1'b0;
         fetch_pc_q    <= RESET_PC;
      end else begin
         state_q       <= state_d;
         fetch_valid_q <= fetch_valid_d;
         flush_q       <= flush_d;
         fetch_pc_q    <= fetch_pc_d;
      end
   end

   assign fetch_valid = fetch_valid_q;
   assign flush       = flush_q;
   assign fetch_pc    = fetch_pc_q;

endmodule : pc_fetch_sequencer
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_pc_fetch_sequencer : directed bench for the PC fetch sequencer
// Revision: 1.0
// ============================================================================
module tb_pc_fetch_sequencer;

   logic        clk = 1'b0;
   logic        clr;
   logic        stall;
   logic        br_taken;
   logic [11:0] br_target;
   logic        jump;
   logic [11:0] jump_target;
   logic        fetch_ready;
   logic        fetch_valid;
   logic [11:0] fetch_pc;
   logic [11:0] pc_next;
   logic        pc_en;
   logic        flush;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_fetch_sequencer #(
      .PC_W     (12),
      .RESET_PC (12'd0)
   ) u_dut (
      .clk         (clk),
      .clr         (clr),
      .stall       (stall),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .jump        (jump),
      .jump_target (jump_target),
      .fetch_ready (fetch_ready),
      .fetch_valid (fetch_valid),
      .fetch_pc    (fetch_pc),
      .pc_next     (pc_next),
      .pc_en       (pc_en),
      .flush       (flush)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
      end
   endtask

   // Drive inputs 1ns after the falling edge, well clear of the rising edge.
   task automatic next_slot();
      @(negedge clk);
      #1;
   endtask

   initial begin
      clr = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = '0;
      jump = 1'b0; jump_target = '0; fetch_ready = 1'b1;
      #1 clr = 1'b1;

      // Reset held for two cycles, then the boot bubble and sequential fetch.
      next_slot(); #1;
      chk("rst_pc",    fetch_pc,    12'h000);
      chk("rst_valid", fetch_valid, 1'b0);
      chk("rst_flush", flush,       1'b0);
      chk("rst_pc_en", pc_en,       1'b0);
      next_slot();
      clr = 1'b0; #1;
      chk("boot_valid", fetch_valid, 1'b0);
      chk("boot_pc_en", pc_en,       1'b0);
      for (int k = 0; k < 4; k++) begin
         next_slot(); #1;
         chk("seq_pc",    fetch_pc,    k[11:0]);
         chk("seq_valid", fetch_valid, 1'b1);
         chk("seq_pc_en", pc_en,       1'b1);
         chk("seq_flush", flush,       1'b0);
      end

      // Wrap-around from 0xFFE.
      next_slot();
      jump = 1'b1; jump_target = 12'hFFE; #1;
      chk("wrap_jmp_en",   pc_en,   1'b1);
      chk("wrap_jmp_next", pc_next, 12'hFFE);
      next_slot();
      jump = 1'b0; #1;
      chk("wrap_pc0",    fetch_pc, 12'hFFE);
      chk("wrap_flush1", flush,    1'b1);
      next_slot(); #1;
      chk("wrap_pc1",    fetch_pc, 12'hFFF);
      chk("wrap_flush0", flush,    1'b0);
      next_slot(); #1;
      chk("wrap_pc2",    fetch_pc, 12'h000);

      // Imem backpressure at 0x010.
      next_slot();
      jump = 1'b1; jump_target = 12'h010; #1;
      next_slot();
      jump = 1'b0; fetch_ready = 1'b0; #1;
      chk("bp_pc",    fetch_pc, 12'h010);
      chk("bp_pc_en", pc_en,    1'b0);
      for (int k = 0; k < 2; k++) begin
         next_slot(); #1;
         chk("bp_hold_pc", fetch_pc, 12'h010);
         chk("bp_hold_en", pc_en,    1'b0);
      end
      next_slot();
      fetch_ready = 1'b1; #1;
      chk("bp_rel_en",   pc_en,   1'b1);
      chk("bp_rel_next", pc_next, 12'h011);
      next_slot(); #1;
      chk("bp_adv_pc", fetch_pc, 12'h011);

      // Branch and jump together: branch wins.
      br_taken = 1'b1; br_target = 12'h200;
      jump = 1'b1; jump_target = 12'h300; #1;
      chk("sim_next", pc_next, 12'h200);
      chk("sim_en",   pc_en,   1'b1);
      next_slot();
      br_taken = 1'b0; jump = 1'b0; #1;
      chk("sim_pc",     fetch_pc, 12'h200);
      chk("sim_flush1", flush,    1'b1);
      next_slot(); #1;
      chk("sim_flush0", flush,    1'b0);
      chk("sim_pc_adv", fetch_pc, 12'h201);

      // Four-cycle stall with jump in cycle 1 and branch in cycle 3.
      stall = 1'b1; jump = 1'b1; jump_target = 12'h080; #1;
      chk("st_c1_en", pc_en, 1'b0);
      next_slot();
      jump = 1'b0; #1;
      chk("st_c2_pc",    fetch_pc,    12'h201);
      chk("st_c2_valid", fetch_valid, 1'b1);
      chk("st_c2_flush", flush,       1'b0);
      chk("st_c2_en",    pc_en,       1'b0);
      next_slot();
      br_taken = 1'b1; br_target = 12'h0C0; #1;
      chk("st_c3_pc", fetch_pc, 12'h201);
      chk("st_c3_en", pc_en,    1'b0);
      next_slot();
      br_taken = 1'b0; #1;
      chk("st_c4_pc",    fetch_pc, 12'h201);
      chk("st_c4_flush", flush,    1'b0);
      next_slot();
      stall = 1'b0; #1;
      chk("st_rel_en",    pc_en,   1'b1);
      chk("st_rel_next",  pc_next, 12'h0C0);
      chk("st_rel_flush", flush,   1'b0);
      next_slot(); #1;
      chk("st_pc",     fetch_pc, 12'h0C0);
      chk("st_flush1", flush,    1'b1);
      next_slot(); #1;
      chk("st_flush0", flush,    1'b0);
      chk("st_pc_adv", fetch_pc, 12'h0C1);

      // Reset asserted mid-stall with a redirect parked.
      stall = 1'b1; jump = 1'b1; jump_target = 12'h123;
      next_slot();
      jump = 1'b0; #1;
      chk("rs_hold_pc", fetch_pc, 12'h0C1);
      clr = 1'b1; #1;
      chk("rs_pc",    fetch_pc,    12'h000);
      chk("rs_valid", fetch_valid, 1'b0);
      chk("rs_pc_en", pc_en,       1'b0);
      chk("rs_flush", flush,       1'b0);
      next_slot();
      clr = 1'b0; stall = 1'b0; #1;
      chk("rs_boot_valid", fetch_valid, 1'b0);
      next_slot(); #1;
      chk("rs_run_pc",    fetch_pc,    12'h000);
      chk("rs_run_valid", fetch_valid, 1'b1);
      chk("rs_run_flush", flush,       1'b0);
      next_slot(); #1;
      chk("rs_seq_pc",    fetch_pc, 12'h001);
      chk("rs_seq_flush", flush,    1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout got=%0d exp=%0d", 0, 1);
      $fatal(1, "bench time limit expired");
   end

endmodule : tb_pc_fetch_sequencer
`default_nettype wire

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Write-side controller for the 12-bit program counter register. It computes the next PC, drives the PC register's data and enable, and issues fetch requests to instruction memory over a valid/ready handshake. It handles sequential advance, branch/jump redirects, pipeline stalls and redirects that arrive during a stall. It sits between the execute/decode redirect logic and the PC register plus imem port.

Parameters:
PC_W, 12, PC width; all PC arithmetic is modulo 2^PC_W.
RESET_PC, 12'd0, PC value loaded on clr.

Ports:
clk  input  1  rising-edge clock.
clr  input  1  asynchronous, active-high reset.
stall  input  1  hold the PC; no advance and no redirect applied.
br_taken  input  1  branch resolved taken this cycle.
br_target  input  PC_W  branch destination.
jump  input  1  jump decoded this cycle.
jump_target  input  PC_W  jump destination.
fetch_ready  input  1  imem accepts the request this cycle.
fetch_valid  output  1  request to imem is valid.
fetch_pc  output  PC_W  address of the current request (registered).
pc_next  output  PC_W  D input to the PC register.
pc_en  output  1  enable for the PC register; high exactly when fetch_pc changes at the next edge.
flush  output  1  registered one-cycle pulse; younger in-flight instructions are squashed.

Behaviour:
- Interface: one clock (clk); reset clr is asynchronous and active-high. All outputs registered except pc_next and pc_en, which are combinational from state and inputs.
- Reset values: fetch_pc=RESET_PC, fetch_valid=0, flush=0, pend_valid=0, state=BOOT. pc_en=0 while clr is high.
- States: BOOT, RUN, HOLD.
- BOOT: fetch_valid=0 for one cycle after clr deasserts, then RUN with fetch_valid=1 and fetch_pc=RESET_PC.
- Redirect select: br_taken has priority over jump in the same cycle; redir = br_taken|jump.
- RUN with stall=0:
  - If redir: pc_next=target, pc_en=1, flush=1 at the next cycle. Any un-accepted request is abandoned.
  - Else if fetch_ready: pc_next=fetch_pc+1, wrapping 0xFFF->0x000, and pc_en=1.
  - Else hold: pc_en=0, fetch_pc stable.
- RUN with stall=1: go to HOLD. fetch_valid stays 1 and fetch_pc is held. A redir this cycle is captured into pend_target/pend_valid.
- HOLD: pc_en=0.
  - Each cycle with redir, pend_target is overwritten by the newest redirect, branch beating jump.
  - On stall=0:
    - If a redir is present, apply it.
    - Else if pend_valid, apply pend_target: pc_en=1, flush pulse, pend_valid cleared.
    - Else behave as RUN for that cycle.
    - Return to RUN.
- A handshake completed during stall does not advance the PC; the same address is re-requested after release.
- flush is high for exactly one cycle per applied redirect. Back-to-back redirects give consecutive flush cycles.
- clr mid-operation: immediate return to reset values and BOOT; pending redirect discarded.
- fetch_valid never drops outside BOOT and reset.

Decomposition:
- Shared package cpu_pkg holds:
  - PC_W and RESET_PC constants.
  - State encoding typedef pcs_state_t (BOOT/RUN/HOLD).
  - pc_inc() function for the wrapping increment.
- One natural sub-module: pc_redirect_buf. It is the one-entry pending-redirect register with branch-over-jump select, built from the existing 12-bit dffe-style register plus a valid bit.

Test Plan:
- Reset, then fetch_ready=1 constantly: clr high for 2 cycles then low. Required: fetch_valid=0 for 1 cycle, then fetch_pc=0,1,2,3; pc_en=1 each accepted cycle; flush=0.
- Wrap-around: run from fetch_pc=0xFFE with fetch_ready=1. Required: fetch_pc=0xFFF, then 0x000.
- Imem backpressure: fetch_pc=0x010 with fetch_ready=0 for 3 cycles. Required: fetch_pc held at 0x010, pc_en=0; advances to 0x011 the cycle after ready=1.
- Simultaneous redirect: br_taken=1 with br_target=0x200 and jump=1 with jump_target=0x300 in the same cycle, stall=0. Required: fetch_pc=0x200, one-cycle flush.
- Redirect during stall: stall=1 for 4 cycles, jump=1 (target 0x080) in cycle 1, then br_taken=1 (target 0x0C0) in cycle 3. Required: fetch_pc held; on release fetch_pc=0x0C0 with a single flush pulse.
- Reset mid-stall with a pending redirect: assert clr. Required: immediate fetch_pc=0, fetch_valid=0, pending redirect lost, and BOOT sequence repeats.
